mem_ctrl_fsm: RTL
=================

Name: mem_ctrl_fsm

Overview:
- Command sequencer upstream of the 7-segment status display.
- Accepts 16-bit read/write requests from the front panel logic and serialises them as bytes over an 8-bit ready/valid link to the external memory agent.
- Collects read data or write status from the same agent.
- Publishes its 13-bit one-hot state and the 16-bit read result, which the display decodes directly.

Parameters:
- RESET_CYCLES, 16, cycles spent in RESET after rst deasserts before entering IDLE (≥1).
- TIMEOUT_CYCLES, 1024, max cycles in READ_WAIT/WRITE_WAIT before abort (used only with MEMCTRL_TIMEOUT_EN).
- OP_READ, 8'h01, opcode byte sent for reads.
- OP_WRITE, 8'h02, opcode byte sent for writes.

Ports:
- clk  in  1  system clock; one clock domain; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_req  in  1  single-cycle read request pulse.
- wr_req  in  1  single-cycle write request pulse.
- addr  in  16  request address; sampled on acceptance.
- wr_data  in  16  write payload; sampled on acceptance.
- busy  out  1  high in every state except IDLE and READ_DONE.
- err  out  1  sticky error flag.
- state  out  13  one-hot state, using the display's encoding (bit0 RESET … bit12 WRITE_WAIT).
- rd_data  out  16  last completed read result.
- tx_byte  out  8  byte to memory agent.
- tx_valid  out  1  tx_byte valid.
- tx_ready  in  1  agent accepts tx_byte this cycle.
- rx_byte  in  8  byte from memory agent.
- rx_valid  in  1  rx_byte valid; no backpressure, block always accepts.

Behaviour:
- Reset:
  - While rst is high: state=RESET, rd_data=0, err=0, tx_valid=0, tx_byte=0, busy=1; internal latches cleared.
  - After rst drops, state stays in RESET for RESET_CYCLES cycles, then enters IDLE.
  - rst asserted in any state returns to RESET on the next edge and aborts any transfer; partial rx bytes are discarded.
- Request acceptance:
  - Requests are accepted only in IDLE or READ_DONE.
  - On acceptance, addr and wr_data are latched and err clears.
  - rd_req and wr_req together: read wins; the write is dropped.
  - Requests in any other state are ignored; no queueing.
- Read path:
  - READ_ST0 sends OP_READ; READ_ST1 sends addr[7:0]; READ_ST2 sends addr[15:8].
  - READ_WAIT takes the first rx byte as the low byte and the second as the high byte.
  - After the second byte, rd_data is updated (single-cycle update, never partial) and state moves to READ_DONE.
  - READ_DONE holds until a new request.
- Write path:
  - WRITE_ST0 sends OP_WRITE; WRITE_ST1 sends addr[7:0]; WRITE_ST2 sends addr[15:8]; WRITE_ST3 sends wr_data[7:0]; WRITE_ST4 sends wr_data[15:8].
  - WRITE_WAIT waits for one status byte: 8'h00 → IDLE with err=0; any other value → IDLE with err=1.
  - rd_data is unchanged by writes.
- Send states:
  - tx_valid=1 with the state's byte.
  - The state advances on the edge where tx_valid&&tx_ready; the next state is visible the following cycle.
  - tx_byte stays stable while stalled; stalls are unbounded.
- tx_valid=0 in all non-send states.
- rx_valid outside READ_WAIT/WRITE_WAIT is ignored.
- state is always exactly one-hot; any illegal encoding recovers to RESET on the next edge.

Optional Feature:
- Macro MEMCTRL_TIMEOUT_EN.
- Defined:
  - A counter runs in READ_WAIT/WRITE_WAIT, cleared on entry and on each rx byte accepted.
  - When it reaches TIMEOUT_CYCLES, state goes to IDLE and err=1; rd_data is unchanged.
- Undefined: wait states wait forever; no counter is synthesised.

Test Plan:
- Reset: hold rst 3 cycles, release → state=13'h0001 for exactly 16 cycles, then 13'h0002; all outputs at reset values throughout.
- Read: rd_req, addr=16'hBEEF, tx_ready=1 → tx bytes 01,EF,BE on consecutive cycles; rx 34 then 12 → state READ_DONE (13'h0040), rd_data=16'h1234, busy=0.
- Write with backpressure: wr_req, addr=16'h0010, wr_data=16'hA55A; tx_ready low 5 cycles in WRITE_ST2 → bytes 02,10,00,5A,A5 in order, tx_byte stable while stalled; rx 00 → IDLE, err=0. Rx 7F instead → IDLE, err=1.
- Simultaneous and ignored requests: rd_req and wr_req in the same IDLE cycle → READ_ST0. wr_req during READ_WAIT → ignored; read completes normally.
- Reset mid-write: assert rst in WRITE_ST3 → RESET next edge, tx_valid=0, rd_data=0; rx bytes arriving afterwards are ignored.
- Timeout (MEMCTRL_TIMEOUT_EN, TIMEOUT_CYCLES=8): read with no rx → IDLE after 8 wait cycles, err=1, rd_data unchanged. One rx byte at cycle 6 restarts the count.

Source files
------------

// File: rtl/mem_ctrl_fsm.sv
// Byte-serial memory command sequencer feeding the 7-segment status display.
// Define MEMCTRL_TIMEOUT_EN to abort READ_WAIT/WRITE_WAIT after TIMEOUT_CYCLES idle cycles.
module mem_ctrl_fsm #(
  parameter int unsigned RESET_CYCLES   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [7:0]  OP_READ        = 8'h01,
  parameter logic [7:0]  OP_WRITE       = 8'h02
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [15:0] addr,
  input  logic [15:0] wr_data,
  output logic        busy,
  output logic        err,
  output logic [12:0] state,
  output logic [15:0] rd_data,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid
);

  if (RESET_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("mem_ctrl_fsm: RESET_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [12:0] {
    S_RESET = 13'h0001,
    S_IDLE  = 13'h0002,
    S_RD0   = 13'h0004,
    S_RD1   = 13'h0008,
    S_RD2   = 13'h0010,
    S_RWAIT = 13'h0020,
    S_RDONE = 13'h0040,
    S_WR0   = 13'h0080,
    S_WR1   = 13'h0100,
    S_WR2   = 13'h0200,
    S_WR3   = 13'h0400,
    S_WR4   = 13'h0800,
    S_WWAIT = 13'h1000
  } state_t;

  localparam int unsigned RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  state_t         cur, nxt;
  logic [RCW-1:0] rcnt;
  logic [15:0]    addr_q, wdata_q;
  logic [7:0]     lo_q;
  logic           got_lo;
  logic           accept_rd, accept_wr;
  logic           in_wait;
  logic           tmo;

  assign state   = cur;
  assign in_wait = (cur == S_RWAIT) || (cur == S_WWAIT);

`ifdef MEMCTRL_TIMEOUT_EN
  localparam int unsigned TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TCW-1:0] tcnt;

  // Counter is held at zero outside the wait states, so entry always starts fresh.
  always_ff @(posedge clk) begin
    if (rst || !in_wait || rx_valid) tcnt <= '0;
    else                             tcnt <= tcnt + TCW'(1);
  end

  assign tmo = in_wait && !rx_valid && (tcnt == TCW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    nxt       = cur;
    busy      = 1'b1;
    tx_valid  = 1'b0;
    tx_byte   = '0;
    accept_rd = 1'b0;
    accept_wr = 1'b0;
    case (cur)
      S_RESET: if (rcnt == RCW'(RESET_CYCLES - 1)) nxt = S_IDLE;
      S_IDLE, S_RDONE: begin
        busy = 1'b0;
        if (rd_req) begin
          accept_rd = 1'b1;
          nxt       = S_RD0;
        end else if (wr_req) begin
          accept_wr = 1'b1;
          nxt       = S_WR0;
        end
      end
      S_RD0: begin
        tx_valid = 1'b1; tx_byte = OP_READ;
        if (tx_ready) nxt = S_RD1;
      end
      S_RD1: begin
        tx_valid = 1'b1; tx_byte = addr_q[7:0];
        if (tx_ready) nxt = S_RD2;
      end
      S_RD2: begin
        tx_valid = 1'b1; tx_byte = addr_q[15:8];
        if (tx_ready) nxt = S_RWAIT;
      end
      S_RWAIT: begin
        if (rx_valid && got_lo) nxt = S_RDONE;
        else if (tmo)           nxt = S_IDLE;
      end
      S_WR0: begin
        tx_valid = 1'b1; tx_byte = OP_WRITE;
        if (tx_ready) nxt = S_WR1;
      end
      S_WR1: begin
        tx_valid = 1'b1; tx_byte = addr_q[7:0];
        if (tx_ready) nxt = S_WR2;
      end
      S_WR2: begin
        tx_valid = 1'b1; tx_byte = addr_q[15:8];
        if (tx_ready) nxt = S_WR3;
      end
      S_WR3: begin
        tx_valid = 1'b1; tx_byte = wdata_q[7:0];
        if (tx_ready) nxt = S_WR4;
      end
      S_WR4: begin
        tx_valid = 1'b1; tx_byte = wdata_q[15:8];
        if (tx_ready) nxt = S_WWAIT;
      end
      S_WWAIT: begin
        if (rx_valid || tmo) nxt = S_IDLE;
      end
      default: nxt = S_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur     <= S_RESET;
      rcnt    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      got_lo  <= 1'b0;
      rd_data <= '0;
      err     <= 1'b0;
    end else begin
      cur  <= nxt;
      rcnt <= (cur == S_RESET) ? rcnt + RCW'(1) : '0;
      if (accept_rd || accept_wr) begin
        addr_q  <= addr;
        wdata_q <= wr_data;
        err     <= 1'b0;
        got_lo  <= 1'b0;
      end
      // Low byte is parked so rd_data only ever changes as a complete word.
      if (cur == S_RWAIT && rx_valid) begin
        if (!got_lo) begin
          lo_q   <= rx_byte;
          got_lo <= 1'b1;
        end else begin
          rd_data <= {rx_byte, lo_q};
          got_lo  <= 1'b0;
        end
      end
      if (cur == S_WWAIT && rx_valid) err <= (rx_byte != 8'h00);
      if (tmo) begin
        err    <= 1'b1;
        got_lo <= 1'b0;
      end
    end
  end

endmodule
